counter: RTL and testbench

Loadable 4-bit up-counter: the program-counter style register of the TD4 learning CPU. Every rising clock edge it increments by one, or it takes a parallel load from `d` when `load` is asserted. It has a single clock domain and an asynchronous active-low clear. Its output feeds instruction-address decode. The jump logic drives `d`/`load`.

---
 rtl/counter.sv | 40 ++++
 tb/tb_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Loadable up-counter used as the TD4 program counter.
// Increments every rising edge unless a parallel load from d is requested.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: load wins over increment; the increment wraps modulo 2^WIDTH.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = d;
    end else begin
      count_d = count_q + ONE;
    end
  end

  // Count register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: tb/tb_counter.sv
// Randomized self-checking bench for counter against a modular-arithmetic model,
// plus directed literal checks for clear, count, load, wrap and load priority.
module tb_counter;

  localparam int W = 4;
  localparam int MOD = 16;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;

  int vectors;
  int miscompares;
  int exp_count;
  bit chk_en;

  counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .d    (d),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: clear while reset is low, otherwise take d or add one mod 16.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_count <= 0;
    else if (load) exp_count <= int'(d);
    else exp_count <= (exp_count + 1) % MOD;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (int'(q) != exp_count || $isunknown(q)) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t: q=%0d expected %0d", $time, q, exp_count);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] want);
    vectors++;
    if (q !== want) begin
      miscompares++;
      $display("FAIL %s: q=%b expected %b", name, q, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] lit;
    vectors     = 0;
    miscompares = 0;
    exp_count   = 0;
    chk_en      = 1'b0;
    reset       = 1'b1;
    load        = 1'b0;
    d           = 4'b0000;
    #1 reset = 1'b0;
    #1 check("reset_state", 4'b0000);
    chk_en = 1'b1;
    tick();
    tick();
    check("reset_hold", 4'b0000);

    // Count to 5, then clear asynchronously between edges.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("count_to_5", 4'b0101);
    reset = 1'b0;
    #1 check("async_clear", 4'b0000);

    // Reset beats load across three edges.
    load = 1'b1;
    d = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_beats_load", 4'b0000);
    end

    // Release, count 1,2,3.
    reset = 1'b1;
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      lit = 4'(i);
      check("count_after_reset", lit);
    end

    // Load then count.
    d = 4'b1010;
    load = 1'b1;
    tick();
    check("load_1010", 4'b1010);
    load = 1'b0;
    tick();
    check("count_after_load", 4'b1011);

    // Wrap-around.
    d = 4'b1110;
    load = 1'b1;
    tick();
    check("load_1110", 4'b1110);
    load = 1'b0;
    tick();
    check("wrap_1111", 4'b1111);
    tick();
    check("wrap_0000", 4'b0000);
    tick();
    check("wrap_0001", 4'b0001);

    // Repeated loads, with d changed between edges.
    load = 1'b1;
    d = 4'b0110;
    tick();
    check("hold_load_1", 4'b0110);
    tick();
    check("hold_load_2", 4'b0110);
    d = 4'b0011;
    #1 check("d_change_between_edges", 4'b0110);
    d = 4'b1001;
    tick();
    check("hold_load_3", 4'b1001);
    load = 1'b0;
    tick();
    check("count_after_hold", 4'b1010);

    // Load 1111 then wrap on the next non-load edge.
    load = 1'b1;
    d = 4'b1111;
    tick();
    load = 1'b0;
    tick();
    check("load_1111_wrap", 4'b0000);

    // Randomized traffic with occasional asynchronous clears.
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 3) == 0);
      d = W'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        #1 check("rand_async_clear", 4'b0000);
      end else begin
        reset = 1'b1;
      end
      tick();
    end
    reset = 1'b1;
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
